// File: rtl/uart_rx_parity_unit_pkg.sv
// Shared definitions for the UART receive path: parity-mode encoding,
// parity-checker FSM states, legal data-width range and the
// expected-parity helper.
package uart_rx_pkg;

    localparam int unsigned DATA_WIDTH_MIN = 5;
    localparam int unsigned DATA_WIDTH_MAX = 9;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAR,
        ST_DONE
    } par_state_e;

    // Parity bit the transmitter should have sent, given the XOR of the data bits.
    function automatic logic expected_parity(input par_mode_e mode, input logic acc);
        case (mode)
            PAR_EVEN: return acc;
            PAR_ODD:  return ~acc;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_parity_unit_if.sv
// Bus between the RX control FSM / data sampler (master) and the parity
// checker (slave).
//   par_en, par_mode : parity config, sampled on frame_start
//   frame_start      : arms a new frame
//   bit_vld          : sampled_bit carries a data or parity bit
//   err_clr          : clears error status
//   par_done         : one-cycle frame-complete pulse
//   par_err          : frame parity result
//   err_sticky       : sticky error flag
//   err_cnt          : saturating error-frame count
interface uart_rx_parity_unit_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 par_en;
    logic [1:0]           par_mode;
    logic                 frame_start;
    logic                 bit_vld;
    logic                 sampled_bit;
    logic                 err_clr;
    logic                 par_done;
    logic                 par_err;
    logic                 err_sticky;
    logic [CNT_WIDTH-1:0] err_cnt;

    modport master (
        output par_en, par_mode, frame_start, bit_vld, sampled_bit, err_clr,
        input  par_done, par_err, err_sticky, err_cnt
    );

    modport slave (
        input  par_en, par_mode, frame_start, bit_vld, sampled_bit, err_clr,
        output par_done, par_err, err_sticky, err_cnt
    );
endinterface

// File: rtl/uart_rx_parity_unit_err_counter.sv
// Saturating error counter with sticky flag. Reusable for parity,
// framing and overrun errors.
//   CLK, RST   : clock, async active-low reset
//   err_inc    : one error event this cycle
//   err_clr    : clear count and flag (an error in the same cycle wins)
//   err_sticky : set on any error, held until err_clr
//   err_cnt    : error count, saturates at all-ones
module uart_err_counter #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 err_inc,
    input  logic                 err_clr,
    output logic                 err_sticky,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (err_inc) begin
            // Clear and error together: the clear takes effect first, so the
            // new error counts as the first one.
            err_sticky <= 1'b1;
            if (err_clr)
                err_cnt <= CNT_WIDTH'(1);
            else if (err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end
    end

endmodule

// File: rtl/uart_rx_parity_unit.sv
// Serial parity checker for the UART receiver. Accumulates parity of the
// sampled data bits, checks the received parity bit against the mode
// latched at frame start, and reports a per-frame result plus error status.
//   CLK, RST : clock, async active-low reset
//   bus      : slave side of uart_rx_parity_unit_if
module uart_rx_parity_unit
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input logic                  CLK,
    input logic                  RST,
    uart_rx_parity_unit_if.slave bus
);

    localparam int unsigned BW = $clog2(DATA_WIDTH_MAX + 1);

    par_state_e    state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          acc_q, acc_d;
    logic          par_en_q, par_en_d;
    par_mode_e     par_mode_q, par_mode_d;
    logic          par_err_q, par_err_d;
    logic          last_bit;
    logic          err_inc;

    assign last_bit = (bit_cnt_q == BW'(DATA_WIDTH - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            acc_q      <= 1'b0;
            par_en_q   <= 1'b0;
            par_mode_q <= PAR_EVEN;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            acc_q      <= acc_d;
            par_en_q   <= par_en_d;
            par_mode_q <= par_mode_d;
            par_err_q  <= par_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        acc_d      = acc_q;
        par_en_d   = par_en_q;
        par_mode_d = par_mode_q;
        par_err_d  = par_err_q;

        // frame_start in any state restarts; a coincident bit_vld is dropped.
        if (bus.frame_start) begin
            state_d    = ST_DATA;
            bit_cnt_d  = '0;
            acc_d      = 1'b0;
            par_en_d   = bus.par_en;
            par_mode_d = par_mode_e'(bus.par_mode);
            par_err_d  = 1'b0;
        end else begin
            case (state_q)
                ST_DATA: begin
                    if (bus.bit_vld) begin
                        acc_d     = acc_q ^ bus.sampled_bit;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (last_bit)
                            state_d = par_en_q ? ST_PAR : ST_DONE;
                    end
                end
                ST_PAR: begin
                    if (bus.bit_vld) begin
                        par_err_d = (bus.sampled_bit != expected_parity(par_mode_q, acc_q));
                        state_d   = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.par_done = (state_q == ST_DONE);
    assign bus.par_err  = par_err_q;
    assign err_inc      = bus.par_done & par_err_q;

    uart_err_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_err_counter (
        .CLK        (CLK),
        .RST        (RST),
        .err_inc    (err_inc),
        .err_clr    (bus.err_clr),
        .err_sticky (bus.err_sticky),
        .err_cnt    (bus.err_cnt)
    );

endmodule

// File: tb/tb_uart_rx_parity_unit.sv
module tb_uart_rx_parity_unit;

    localparam logic [1:0] M_EVEN  = 2'b00;
    localparam logic [1:0] M_ODD   = 2'b01;
    localparam logic [1:0] M_MARK  = 2'b10;
    localparam logic [1:0] M_SPACE = 2'b11;

    logic CLK;
    logic RST;

    uart_rx_parity_unit_if #(.CNT_WIDTH(8)) bus8 ();
    uart_rx_parity_unit_if #(.CNT_WIDTH(2)) bus2 ();

    // Second instance sees identical stimulus, only the counter width differs.
    assign bus2.par_en      = bus8.par_en;
    assign bus2.par_mode    = bus8.par_mode;
    assign bus2.frame_start = bus8.frame_start;
    assign bus2.bit_vld     = bus8.bit_vld;
    assign bus2.sampled_bit = bus8.sampled_bit;
    assign bus2.err_clr     = bus8.err_clr;

    uart_rx_parity_unit #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut8 (.CLK(CLK), .RST(RST), .bus(bus8));
    uart_rx_parity_unit #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       err;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
        logic       sticky;
    } exp_t;
    exp_t sb_q[$];

    int   m_cnt8 = 0;
    int   m_cnt2 = 0;
    logic m_sticky = 1'b0;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [7:0] data;
        logic       pbit;
        logic       clr;
        logic       exp_err;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every par_done must match a queued frame result.
    always @(negedge CLK) begin
        if (RST === 1'b1 && bus8.par_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_par_done: got pulse expected none at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("par_err", {31'd0, bus8.par_err}, {31'd0, e.err});
                chk("par_err_c2", {31'd0, bus2.par_err}, {31'd0, e.err});
                chk("par_done_c2", {31'd0, bus2.par_done}, 32'd1);
                @(negedge CLK);
                chk("err_cnt8", {24'd0, bus8.err_cnt}, {24'd0, e.cnt8});
                chk("err_cnt2", {30'd0, bus2.err_cnt}, {30'd0, e.cnt2});
                chk("err_sticky", {31'd0, bus8.err_sticky}, {31'd0, e.sticky});
            end
        end
    end

    task automatic start(input logic en, input logic [1:0] mode);
        @(negedge CLK);
        bus8.frame_start = 1'b1;
        bus8.par_en      = en;
        bus8.par_mode    = mode;
    endtask

    // Drives the bits of a frame whose frame_start is already on the bus
    // (already=0) or already accepted (already=1), then checks the done pulse.
    task automatic body(input logic en, input logic [1:0] mode, input logic [7:0] data,
                        input logic pbit, input logic clr, input logic exp_err,
                        input logic chain, input logic next_en, input logic [1:0] next_mode,
                        input logic already);
        int   nbits;
        logic b;
        exp_t e;
        if (!already) @(negedge CLK);
        bus8.frame_start = 1'b0;
        bus8.bit_vld     = 1'b0;
        bus8.par_en      = ~en;      // config changes mid-frame must be ignored
        bus8.par_mode    = ~mode;
        nbits = en ? 9 : 8;
        for (int i = 0; i < nbits; i++) begin
            b = (i < 8) ? data[i] : pbit;
            bus8.bit_vld     = 1'b1;
            bus8.sampled_bit = b;
            if (i == nbits - 1) begin
                if (clr) begin
                    m_cnt8   = exp_err ? 1 : 0;
                    m_cnt2   = exp_err ? 1 : 0;
                    m_sticky = exp_err;
                end else if (exp_err) begin
                    if (m_cnt8 < 255) m_cnt8++;
                    if (m_cnt2 < 3) m_cnt2++;
                    m_sticky = 1'b1;
                end
                e.err = exp_err; e.cnt8 = 8'(m_cnt8); e.cnt2 = 2'(m_cnt2); e.sticky = m_sticky;
                sb_q.push_back(e);
            end
            @(negedge CLK);
            bus8.bit_vld = 1'b0;
            if (i < nbits - 1 && $urandom_range(0, 2) == 0) @(negedge CLK);
        end
        chk("done_latency", {31'd0, bus8.par_done}, 32'd1);
        bus8.err_clr = clr;
        if (chain) begin
            bus8.frame_start = 1'b1;
            bus8.par_en      = next_en;
            bus8.par_mode    = next_mode;
        end
        @(negedge CLK);
        bus8.frame_start = 1'b0;
        bus8.err_clr     = 1'b0;
        chk("done_one_cycle", {31'd0, bus8.par_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            en  mode     data   pbit clr  exp_err
        vecs[0]  = '{1'b1, M_EVEN,  8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, M_ODD,   8'h01, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, M_ODD,   8'h01, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, M_MARK,  8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, M_SPACE, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, M_ODD,   8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, M_EVEN,  8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, M_EVEN,  8'h07, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, M_ODD,   8'h00, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, M_SPACE, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, M_MARK,  8'h5A, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, M_EVEN,  8'h5A, 1'b0, 1'b0, 1'b0};

        RST = 1'b0;
        bus8.par_en = 1'b0; bus8.par_mode = 2'b00; bus8.frame_start = 1'b0;
        bus8.bit_vld = 1'b0; bus8.sampled_bit = 1'b0; bus8.err_clr = 1'b0;
        #23;
        chk("rst_par_done", {31'd0, bus8.par_done}, 32'd0);
        chk("rst_par_err", {31'd0, bus8.par_err}, 32'd0);
        chk("rst_sticky", {31'd0, bus8.err_sticky}, 32'd0);
        chk("rst_cnt8", {24'd0, bus8.err_cnt}, 32'd0);
        chk("rst_cnt2", {30'd0, bus2.err_cnt}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        foreach (vecs[k]) begin
            start(vecs[k].en, vecs[k].mode);
            body(vecs[k].en, vecs[k].mode, vecs[k].data, vecs[k].pbit, vecs[k].clr,
                 vecs[k].exp_err, 1'b0, 1'b0, 2'b00, 1'b0);
            repeat (2) @(negedge CLK);
        end

        // Abort after 4 data bits; the restart cycle also carries a bit_vld
        // that must be dropped.
        start(1'b1, M_ODD);
        @(negedge CLK);
        bus8.frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus8.bit_vld = 1'b1; bus8.sampled_bit = 1'b1;
            @(negedge CLK);
        end
        bus8.frame_start = 1'b1; bus8.par_en = 1'b1; bus8.par_mode = M_EVEN;
        bus8.bit_vld = 1'b1; bus8.sampled_bit = 1'b1;
        body(1'b1, M_EVEN, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        repeat (2) @(negedge CLK);

        // frame_start during DONE: the pulse still happens and the next frame runs.
        start(1'b1, M_ODD);
        body(1'b1, M_ODD, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, M_MARK, 1'b0);
        body(1'b1, M_MARK, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        repeat (2) @(negedge CLK);
        chk("par_err_held", {31'd0, bus8.par_err}, 32'd1);

        // Reset while waiting for the parity bit.
        start(1'b1, M_ODD);
        @(negedge CLK);
        bus8.frame_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus8.bit_vld = 1'b1; bus8.sampled_bit = 1'(i % 2);
            @(negedge CLK);
        end
        bus8.bit_vld = 1'b0;
        #2 RST = 1'b0;
        #1;
        chk("arst_par_done", {31'd0, bus8.par_done}, 32'd0);
        chk("arst_par_err", {31'd0, bus8.par_err}, 32'd0);
        chk("arst_sticky", {31'd0, bus8.err_sticky}, 32'd0);
        chk("arst_cnt8", {24'd0, bus8.err_cnt}, 32'd0);
        chk("arst_cnt2", {30'd0, bus2.err_cnt}, 32'd0);
        m_cnt8 = 0; m_cnt2 = 0; m_sticky = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus8.bit_vld = 1'b1; bus8.sampled_bit = 1'(i % 2);
            @(negedge CLK);
            bus8.bit_vld = 1'b0;
            @(negedge CLK);
        end

        // One error frame, then a standalone clear.
        start(1'b1, M_ODD);
        body(1'b1, M_ODD, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        repeat (2) @(negedge CLK);
        bus8.err_clr = 1'b1;
        @(negedge CLK);
        bus8.err_clr = 1'b0;
        m_cnt8 = 0; m_cnt2 = 0; m_sticky = 1'b0;
        chk("clr_cnt8", {24'd0, bus8.err_cnt}, 32'(m_cnt8));
        chk("clr_cnt2", {30'd0, bus2.err_cnt}, 32'(m_cnt2));
        chk("clr_sticky", {31'd0, bus8.err_sticky}, {31'd0, m_sticky});

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge CLK);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_parity_unit.md
Name: uart_rx_parity_unit

Overview:
Parametrised serial parity checker for the UART receiver. It accumulates parity bit-by-bit as the RX FSM delivers sampled data bits, captures the received parity bit, and reports a per-frame error pulse. It supports configurable data width and four parity modes, latched per frame, plus a saturating error counter and a sticky error flag for status registers. It sits between the data-sampling block and the RX control FSM, in parallel with the deserializer.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
CNT_WIDTH, 8, width of the frame-error counter.

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous reset, active-low
par_en  input  1  parity enable; sampled only on frame_start
par_mode  input  2  parity mode; sampled only on frame_start: 00 even, 01 odd, 10 mark (bit must be 1), 11 space (bit must be 0)
frame_start  input  1  one-cycle pulse at start-bit acceptance; arms a new frame
bit_vld  input  1  one-cycle strobe: sampled_bit is a valid data or parity bit
sampled_bit  input  1  bit value from data sampling
err_clr  input  1  clears err_sticky and err_cnt
par_done  output  1  one-cycle pulse: frame parity check complete
par_err  output  1  frame result; valid from par_done, held until next frame_start
err_sticky  output  1  set on any parity error, held until err_clr
err_cnt  output  CNT_WIDTH  saturating count of parity-error frames

Behaviour:
- Reset (RST low, async): state IDLE, bit counter 0, accumulator 0, par_done 0, par_err 0, err_sticky 0, err_cnt 0.
- FSM states: IDLE, DATA, PAR, DONE.
- IDLE: frame_start -> DATA. On the same edge latch par_en/par_mode, clear the accumulator and bit counter, and clear par_err.
- DATA: each bit_vld XORs sampled_bit into the accumulator and increments the counter. On the DATA_WIDTH-th bit_vld: go to PAR if latched par_en=1, else go to DONE.
- PAR: on bit_vld, compute the expected bit: even = acc, odd = ~acc, mark = 1, space = 0. Register par_err = (sampled_bit != expected), then go to DONE.
- DONE: par_done=1 for exactly this one cycle, then return to IDLE.
- Latency: par_done rises on the clock after the edge that accepts the parity bit. With par_en=0, par_err stays 0 and no counters change.
- On par_done with par_err=1: set err_sticky; err_cnt increments and saturates at all-ones (no wrap).
- err_clr and an error completing in the same cycle: the error wins. err_cnt becomes 1 and err_sticky stays 1.
- frame_start in DATA or PAR aborts the current frame and restarts from fresh, with no par_done for the aborted frame. frame_start in DONE is accepted: DONE still pulses, and the next state is DATA with the new latch.
- bit_vld in IDLE or DONE is ignored. bit_vld and frame_start in the same cycle: frame_start wins and the bit is dropped.
- par_mode/par_en changes mid-frame have no effect on the current frame.
- RST low mid-frame: immediate return to reset values; no par_done.

Decomposition:
- Shared package uart_rx_pkg: parity-mode enum (PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_MARK=2'b10, PAR_SPACE=2'b11), FSM state typedef, DATA_WIDTH range constants.
- One sub-module: uart_err_counter (saturating counter plus sticky flag with clear priority rule), reusable for framing and overrun errors.

Test Plan:
- Even, DATA_WIDTH=8, data 8'hA5 LSB-first, parity bit 0 -> par_done pulse one cycle after parity bit_vld; par_err=0; err_cnt=0.
- Odd, data 8'h01, parity bit 1 -> par_err=1, err_sticky=1, err_cnt=1. A following frame with data 8'h01 and parity 0 -> par_err=0, err_cnt stays 1.
- Mark and space modes, parity bit 0 -> mark: par_err=1; space: par_err=0. With par_en=0 and 8 bits -> par_done one cycle after the 8th bit, par_err=0.
- CNT_WIDTH=2, five error frames -> err_cnt 1,2,3,3,3. err_clr coincident with the 6th error's par_done -> err_cnt=1, err_sticky=1.
- frame_start after 4 data bits, then a full clean even frame with data 8'hFF and parity 0 -> exactly one par_done, par_err=0.
- RST pulsed low during PAR -> all outputs 0 immediately. bit_vld pulses before the next frame_start -> no par_done.
